fft_bitrev_reorder: RTL and testbench

Streaming reorder buffer on the output side of `top_FFT`. The FFT core emits each 1024-point frame in bit-reversed index order. This block collects each frame and re-emits it in natural index order at one sample per clock. It uses a ping-pong pair of 1024-entry banks, so a continuous input stream produces a continuous output stream with a fixed one-frame delay.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_reorder_ram.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 121 ++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Purpose: shared FFT constants and the bit-reversal helper used by the core, the reorder buffer and benches.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fft_pkg;

  localparam int FFT_N_LOG2 = 10;
  localparam int FFT_DW     = 24;

  // Reverse the low n_log2 bits of idx; bits above n_log2 are ignored.
  // Fixed 32-step loop keeps the hardware a pure wire permutation when
  // n_log2 is a constant.
  function automatic int bitrev(input int idx, input int n_log2);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < n_log2) r = {r[30:0], idx[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Purpose: simple dual-port RAM backing the two reorder banks; address is {bank, index}.
// Latency: 1 cycle from i_re/i_raddr to o_rdata (registered read port).
// Backpressure: none; one write and one read may be issued every cycle.
//
// Ports:
//   i_clk              clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr       read request; o_rdata valid the following cycle
module fft_reorder_ram #(
  parameter int AW = 11,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_q;

  // No reset on array or read register so the whole thing maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Purpose: collect bit-reversed FFT frames into ping-pong banks and replay them in natural order.
// Latency: output n of a frame appears 2+n cycles after the frame's last sample is captured.
// Backpressure: none; input may stall freely, output streams 1024 contiguous samples per frame.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_sof/in_data     bit-reversed input stream
//   out_valid/out_sof/out_data  natural-order output stream
//   sof_err                     one-cycle pulse when an in_sof resynchronises a partial frame
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_sof,
  output logic [DW-1:0] out_data,
  output logic          sof_err
);

  localparam logic [N_LOG2-1:0] LAST = '1;

  logic              r_synced;
  logic              r_wbank;
  logic              r_rbank;
  logic [1:0]        r_full;
  logic [N_LOG2-1:0] r_wcnt;
  logic [N_LOG2-1:0] r_rcnt;
  logic              r_sof_err;
  logic              r_out_valid;
  logic              r_out_sof;

  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_frame_done;
  logic              w_read_done;
  logic [N_LOG2-1:0] w_widx;
  logic [N_LOG2-1:0] w_waddr_lo;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;
  logic [DW-1:0]     w_rdata;

  // Samples before the first sof are dropped; sof always restarts the bank at index 0.
  assign w_wr_en      = in_valid && (r_synced || in_sof);
  assign w_widx       = in_sof ? '0 : r_wcnt;
  assign w_waddr_lo   = N_LOG2'(bitrev(int'(w_widx), N_LOG2));
  assign w_frame_done = w_wr_en && (w_widx == LAST);

  // Reader runs whenever its bank is full; back-to-back frames need no idle cycle.
  assign w_rd_en     = r_full[r_rbank];
  assign w_read_done = w_rd_en && (r_rcnt == LAST);

  assign w_full_set = {w_frame_done &&  r_wbank, w_frame_done && !r_wbank};
  assign w_full_clr = {w_read_done  &&  r_rbank, w_read_done  && !r_rbank};

  // Write side and sync tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_synced  <= 1'b0;
      r_wcnt    <= '0;
      r_wbank   <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      if (in_valid && in_sof) r_synced <= 1'b1;
      r_sof_err <= in_valid && in_sof && r_synced && (r_wcnt != '0);
      if (w_wr_en) begin
        // Natural wrap at LAST lets later frames arrive without in_sof.
        r_wcnt <= w_widx + 1'b1;
        if (w_frame_done) r_wbank <= ~r_wbank;
      end
    end
  end

  // Bank full flags: writer sets on frame completion, reader clears after its last read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_full <= 2'b00;
    else        r_full <= (r_full | w_full_set) & ~w_full_clr;
  end

  // Read side; output flags align with the RAM's registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcnt      <= '0;
      r_rbank     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
    end else begin
      if (w_rd_en) r_rcnt <= r_rcnt + 1'b1;
      if (w_read_done) r_rbank <= ~r_rbank;
      r_out_valid <= w_rd_en;
      r_out_sof   <= w_rd_en && (r_rcnt == '0);
    end
  end

  fft_reorder_ram #(
    .AW (N_LOG2 + 1),
    .DW (DW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_en),
    .i_waddr ({r_wbank, w_waddr_lo}),
    .i_wdata (in_data),
    .i_re    (w_rd_en),
    .i_raddr ({r_rbank, r_rcnt}),
    .o_rdata (w_rdata)
  );

  // RAM output register has no reset; gating by valid keeps out_data at 0 in
  // reset and between frames.
  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_data  = r_out_valid ? w_rdata : '0;
  assign sof_err   = r_sof_err;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  localparam int NPT = 1 << FFT_N_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sof = 1'b0;
  logic [FFT_DW-1:0] in_data = '0;
  logic              out_valid;
  logic              out_sof;
  logic [FFT_DW-1:0] out_data;
  logic              sof_err;

  typedef struct {
    int dat;
    bit sof;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   err_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_len = 0;
  int last_run = 0;
  int err_cnt = 0;
  int first_sof_cyc = -1;
  bit cap_en = 1'b1;
  int cap_idx = 0;
  int cap [NPT];

  fft_bitrev_reorder #(
    .N_LOG2 (FFT_N_LOG2),
    .DW     (FFT_DW)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_data  (out_data),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output sample, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.w_wr_en) chk("no_overflow", int'(dut.r_full[dut.r_wbank]), 0);
      if (out_valid) begin
        run_len++;
        if (cap_en && cap_idx < NPT) begin
          cap[cap_idx] = int'(out_data);
          cap_idx++;
        end
        if (out_sof && first_sof_cyc < 0) first_sof_cyc = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", int'(out_data), mon_e.dat);
          chk("out_sof", int'(out_sof), int'(mon_e.sof));
          chk("out_cycle", cyc, mon_e.cyc);
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        if (out_sof) chk("sof_without_valid", 1, 0);
      end
      if (sof_err) begin
        err_cnt++;
        if (err_q.size() == 0) chk("unexpected_sof_err", 1, 0);
        else chk("sof_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // One input cycle: drive at posedge+1, captured at the next rising edge.
  task automatic step(input bit v, input bit s, input int d);
    in_valid = v;
    in_sof   = s;
    in_data  = FFT_DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  // Sends samples k=0..1023 with payload base+k; output n must carry base+bitrev(n)
  // and appear two cycles after the last capture plus n.
  task automatic send_frame(input int base, input bit sof_first, input bit toggle,
                            output int last_c);
    last_c = 0;
    for (int k = 0; k < NPT; k++) begin
      if (toggle && k > 0) step(1'b0, 1'b0, 0);
      last_c = cyc;
      step(1'b1, sof_first && (k == 0), base + k);
    end
    for (int n = 0; n < NPT; n++)
      sb.push_back('{dat: base + bitrev(n, FFT_N_LOG2), sof: (n == 0), cyc: last_c + 2 + n});
  endtask

  initial begin
    int lc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sof", int'(out_sof), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_sof_err", int'(sof_err), 0);
    rst_n = 1'b1;

    // Single frame at cycle 20, payload k.
    while (cyc < 20) step(1'b0, 1'b0, 0);
    send_frame(0, 1'b1, 1'b0, lc);
    while (cyc < 2100) step(1'b0, 1'b0, 0);
    chk("A_out_sof_cycle", first_sof_cyc, 1045);
    chk("A_n0", cap[0], 0);
    chk("A_n1", cap[1], 512);
    chk("A_n2", cap[2], 256);
    chk("A_n3", cap[3], 768);
    chk("A_n1023", cap[1023], 1023);
    chk("A_valid_run", last_run, 1024);
    chk("A_pending", sb.size(), 0);
    cap_en = 1'b0;

    // Three back-to-back frames, sof only on the first.
    send_frame(0 * 4096, 1'b1, 1'b0, lc);
    send_frame(1 * 4096, 1'b0, 1'b0, lc);
    send_frame(2 * 4096, 1'b0, 1'b0, lc);
    idle(1100);
    chk("B_valid_run", last_run, 3072);
    chk("B_pending", sb.size(), 0);

    // in_valid toggling 1/0.
    send_frame(24'h100000, 1'b1, 1'b1, lc);
    idle(1100);
    chk("C_valid_run", last_run, 1024);
    chk("C_pending", sb.size(), 0);

    // Resync at wcnt=300: partial frame dropped, sof_err the cycle after the sof.
    for (int k = 0; k < 300; k++) step(1'b1, k == 0, 24'h500000 + k);
    err_q.push_back(cyc + 1);
    send_frame(24'h600000, 1'b1, 1'b0, lc);
    idle(1100);
    chk("D_sof_err_count", err_cnt, 1);
    chk("D_err_pending", err_q.size(), 0);
    chk("D_valid_run", last_run, 1024);
    chk("D_pending", sb.size(), 0);

    // Reset while output n=500 is on the bus.
    send_frame(24'h700000, 1'b1, 1'b0, lc);
    while (cyc < lc + 502) step(1'b0, 1'b0, 0);
    chk("E_pre_valid", int'(out_valid), 1);
    chk("E_pre_data", int'(out_data), 24'h700000 + bitrev(500, FFT_N_LOG2));
    rst_n = 1'b0;
    sb.delete();
    run_len = 0;
    last_run = 0;
    #1;
    chk("E_rst_out_valid", int'(out_valid), 0);
    chk("E_rst_out_sof", int'(out_sof), 0);
    chk("E_rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1100);
    chk("E_no_stale_output", last_run, 0);

    // After reset: 100 samples without sof are ignored, then a clean frame.
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0, 24'h800000 + k);
    send_frame(24'h900000, 1'b1, 1'b0, lc);
    idle(1100);
    chk("F_sof_err_count", err_cnt, 1);
    chk("F_valid_run", last_run, 1024);
    chk("F_pending", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
